// File: rtl/nn_pkg.sv
// Shared definitions for the fully-connected layer engine: activation codes,
// FSM encoding and the saturation helper.
package nn_pkg;

    localparam int DW_DEF   = 16;
    localparam int FRAC_DEF = 8;

    localparam logic [1:0] ACT_NONE = 2'd0;
    localparam logic [1:0] ACT_RELU = 2'd1;
    localparam logic [1:0] ACT_HSIG = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_DRAIN = 3'd2,
        ST_ACT   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Returns {above_max, below_min} for a signed value against a w-bit signed range.
    function automatic logic [1:0] sat_flags(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        return {x > hi, x < lo};
    endfunction

endpackage

// File: rtl/nn_mac_act.sv
// Signed MAC accumulator with bias alignment, rescale, saturation and activation.
// Result is combinational from the accumulator; accumulate/clear take effect on the next edge.
module nn_mac_act
    import nn_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int FRAC  = FRAC_DEF,
    parameter int ACC_W = 48
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          mac_en,
    input  logic          bias_en,
    input  logic [DW-1:0] in_data,
    input  logic [DW-1:0] w_data,
    input  logic [1:0]    act_mode,
    output logic [DW-1:0] result
);

    localparam logic signed [DW+1:0] HALF = (DW+2)'(1) <<< (FRAC - 1);
    localparam logic signed [DW+1:0] ONE  = (DW+2)'(1) <<< FRAC;
    localparam logic signed [DW-1:0] Y_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] Y_MIN = {1'b1, {(DW-1){1'b0}}};

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [2*DW-1:0]  prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W-1:0] acc_shr;
    logic [1:0]              ovf;
    logic signed [DW-1:0]    y_sat;
    logic signed [DW+1:0]    hs;

    assign prod     = $signed(in_data) * $signed(w_data);
    assign prod_ext = ACC_W'(prod);
    // Bias is stored in the same Q format as activations, so align it to the product scale.
    assign bias_ext = ACC_W'($signed(w_data)) <<< FRAC;

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (mac_en) begin
            acc_d = acc_q + prod_ext;
        end else if (bias_en) begin
            acc_d = acc_q + bias_ext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_shr = acc_q >>> FRAC;
    assign ovf     = sat_flags(64'(acc_shr), DW);

    always_comb begin
        y_sat = $signed(acc_shr[DW-1:0]);
        if (ovf[1]) begin
            y_sat = Y_MAX;
        end else if (ovf[0]) begin
            y_sat = Y_MIN;
        end
    end

    assign hs = (DW+2)'(y_sat >>> 2) + HALF;

    always_comb begin
        result = y_sat;
        case (act_mode)
            ACT_RELU: begin
                if (y_sat[DW-1]) begin
                    result = '0;
                end
            end
            ACT_HSIG: begin
                if (hs < 0) begin
                    result = '0;
                end else if (hs > ONE) begin
                    result = ONE[DW-1:0];
                end else begin
                    result = hs[DW-1:0];
                end
            end
            default: result = y_sat;
        endcase
    end

endmodule

// File: rtl/nn_fc_layer_engine.sv
// Fully-connected layer: streams activations and weight rows from synchronous ROMs through one MAC.
// done pulses NUM_OUT*(NUM_IN+3)+1 cycles after start is accepted; start is ignored unless idle.
module nn_fc_layer_engine
    import nn_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int FRAC    = FRAC_DEF,
    parameter int AW      = 17,
    parameter int NUM_IN  = 784,
    parameter int NUM_OUT = 10,
    parameter int ACC_W   = 48
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            act_mode,
    input  logic [AW-1:0]         in_base,
    input  logic [AW-1:0]         w_base,
    output logic [AW-1:0]         addr_in,
    input  logic [DW-1:0]         in_data,
    output logic [AW-1:0]         addr_w,
    input  logic [DW-1:0]         w_data,
    output logic                  busy,
    output logic                  done,
    output logic                  out_valid,
    output logic [NUM_OUT*DW-1:0] out_flat
);

    localparam int IW = $clog2(NUM_IN + 1);
    localparam int NW = $clog2(NUM_OUT + 1);

    state_t               state_q, state_d;
    logic [IW-1:0]        i_q, i_d;
    logic [NW-1:0]        n_q, n_d;
    logic [AW-1:0]        addr_in_q, addr_in_d;
    logic [AW-1:0]        addr_w_q, addr_w_d;
    logic [AW-1:0]        in_base_q, in_base_d;
    logic [1:0]           mode_q, mode_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 valid_q, valid_d;
    logic [NUM_OUT*DW-1:0] out_q;

    logic                 mac_en;
    logic                 bias_en;
    logic                 acc_clr;
    logic                 out_we;
    logic [DW-1:0]        act_res;

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        n_d       = n_q;
        addr_in_d = addr_in_q;
        addr_w_d  = addr_w_q;
        in_base_d = in_base_q;
        mode_d    = mode_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        valid_d   = valid_q;
        mac_en    = 1'b0;
        bias_en   = 1'b0;
        acc_clr   = 1'b0;
        out_we    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // done_q marks the completion cycle, in which a new start is not taken.
                if (start && !done_q) begin
                    state_d   = ST_FETCH;
                    i_d       = '0;
                    n_d       = '0;
                    addr_in_d = in_base;
                    addr_w_d  = w_base;
                    in_base_d = in_base;
                    mode_d    = act_mode;
                    busy_d    = 1'b1;
                    valid_d   = 1'b0;
                    acc_clr   = 1'b1;
                end
            end
            ST_FETCH: begin
                // ROM data lags the address by one cycle, so slot 0 has nothing to accumulate yet.
                mac_en = (i_q != '0);
                if (int'(i_q) == NUM_IN) begin
                    state_d = ST_DRAIN;
                end else begin
                    i_d      = i_q + 1'b1;
                    addr_w_d = addr_w_q + 1'b1;
                    if (int'(i_q) + 1 < NUM_IN) begin
                        addr_in_d = addr_in_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                bias_en = 1'b1;
                state_d = ST_ACT;
            end
            ST_ACT: begin
                out_we  = 1'b1;
                acc_clr = 1'b1;
                if (int'(n_q) == NUM_OUT - 1) begin
                    state_d = ST_DONE;
                end else begin
                    state_d   = ST_FETCH;
                    n_d       = n_q + 1'b1;
                    i_d       = '0;
                    addr_w_d  = addr_w_q + 1'b1;
                    addr_in_d = in_base_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                valid_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            i_q       <= '0;
            n_q       <= '0;
            addr_in_q <= '0;
            addr_w_q  <= '0;
            in_base_q <= '0;
            mode_q    <= ACT_NONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            n_q       <= n_d;
            addr_in_q <= addr_in_d;
            addr_w_q  <= addr_w_d;
            in_base_q <= in_base_d;
            mode_q    <= mode_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
        end else if (out_we) begin
            out_q[int'(n_q)*DW +: DW] <= act_res;
        end
    end

    nn_mac_act #(
        .DW    (DW),
        .FRAC  (FRAC),
        .ACC_W (ACC_W)
    ) u_mac_act (
        .clk      (clk),
        .rst      (rst),
        .clr      (acc_clr),
        .mac_en   (mac_en),
        .bias_en  (bias_en),
        .in_data  (in_data),
        .w_data   (w_data),
        .act_mode (mode_q),
        .result   (act_res)
    );

    assign addr_in   = addr_in_q;
    assign addr_w    = addr_w_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = valid_q;
    assign out_flat  = out_q;

endmodule

// File: tb/tb_nn_fc_layer_engine.sv
// Directed bench for nn_fc_layer_engine with an arithmetic reference model and per-cycle compare.
module tb_nn_fc_layer_engine;

    localparam int DW    = 16;
    localparam int FRAC  = 8;
    localparam int AW    = 17;
    localparam int NI    = 4;
    localparam int NO    = 2;
    localparam int ACC_W = 48;
    localparam int P     = NI + 3;
    localparam int TOT   = NO * P + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    act_mode = 2'd0;
    logic [AW-1:0] in_base = '0;
    logic [AW-1:0] w_base = '0;
    logic [AW-1:0] addr_in;
    logic [AW-1:0] addr_w;
    logic [DW-1:0] in_data = '0;
    logic [DW-1:0] w_data = '0;
    logic          busy;
    logic          done;
    logic          out_valid;
    logic [NO*DW-1:0] out_flat;

    int total = 0;
    int bad   = 0;

    logic [15:0] act_rom [64];
    logic [15:0] w_rom   [64];

    nn_fc_layer_engine #(
        .DW(DW), .FRAC(FRAC), .AW(AW), .NUM_IN(NI), .NUM_OUT(NO), .ACC_W(ACC_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .act_mode(act_mode),
        .in_base(in_base), .w_base(w_base),
        .addr_in(addr_in), .in_data(in_data),
        .addr_w(addr_w), .w_data(w_data),
        .busy(busy), .done(done), .out_valid(out_valid), .out_flat(out_flat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        in_data <= act_rom[addr_in[5:0]];
        w_data  <= w_rom[addr_w[5:0]];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_neuron(input int n, input int mode, input int ib, input int wb);
        longint acc;
        longint y;
        int row;
        row = wb + n * (NI + 1);
        acc = 0;
        for (int i = 0; i < NI; i++)
            acc += longint'($signed(act_rom[(ib + i) % 64])) * longint'($signed(w_rom[(row + i) % 64]));
        acc += longint'($signed(w_rom[(row + NI) % 64])) * (longint'(1) << FRAC);
        y = acc >>> FRAC;
        if (y > 32767) y = 32767;
        else if (y < -32768) y = -32768;
        if (mode == 1 && y < 0) y = 0;
        else if (mode == 2) begin
            y = (y >>> 2) + (1 << (FRAC - 1));
            if (y < 0) y = 0;
            else if (y > (1 << FRAC)) y = 1 << FRAC;
        end
        return 16'(y);
    endfunction

    // Model: mk counts edges since start acceptance (-1 or >TOT means idle).
    int          mk = -1;
    bit          mvalid = 1'b0;
    int          m_ib = 0;
    int          m_wb = 0;
    logic [15:0] mexp [NO];
    logic [15:0] mout [NO];
    bit          check_en = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mk = -1;
            mvalid = 1'b0;
            for (int i = 0; i < NO; i++) mout[i] = '0;
        end else if ((mk < 0 || mk > TOT) && start) begin
            mk = 0;
            m_ib = int'(in_base);
            m_wb = int'(w_base);
            mvalid = 1'b0;
            for (int i = 0; i < NO; i++) mexp[i] = ref_neuron(i, int'(act_mode), m_ib, m_wb);
        end else if (mk >= 0 && mk <= TOT) begin
            mk++;
            if (mk % P == 0 && mk <= NO * P) mout[mk / P - 1] = mexp[mk / P - 1];
            if (mk == TOT) mvalid = 1'b1;
        end
    end

    always @(negedge clk) begin
        logic [NO*DW-1:0] ev;
        int j;
        int n;
        if (check_en && !rst) begin
            for (int i = 0; i < NO; i++) ev[i*DW +: DW] = mout[i];
            check("busy", busy, (mk >= 0 && mk < TOT));
            check("done", done, (mk == TOT));
            check("out_valid", out_valid, mvalid);
            check("out_flat", out_flat, ev);
            if (mk >= 0 && mk < NO * P) begin
                j = mk % P;
                n = mk / P;
                check("addr_w", addr_w, (m_wb + n * (NI + 1) + (j < NI ? j : NI)) & ((1 << AW) - 1));
                check("addr_in", addr_in, (m_ib + (j < NI - 1 ? j : NI - 1)) & ((1 << AW) - 1));
            end
        end
    end

    task automatic run_layer(input string tag, input logic [1:0] mode, input int ib, input int wb,
                             input logic [15:0] e0, input logic [15:0] e1, input bit inject);
        int k;
        bit seen;
        @(negedge clk);
        act_mode = mode;
        in_base  = AW'(ib);
        w_base   = AW'(wb);
        start    = 1'b1;
        k = -1;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            start = 1'b0;
            k++;
            if (inject && k == 3) begin
                start = 1'b1; act_mode = 2'd2; in_base = AW'(16); w_base = AW'(32);
            end
            if (done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, seen, 1);
        check({tag, "_latency"}, k, TOT);
        check({tag, "_out0"}, out_flat[15:0], e0);
        check({tag, "_out1"}, out_flat[31:16], e1);
        if (inject) begin
            start = 1'b1; act_mode = 2'd2; in_base = AW'(16); w_base = AW'(32);
            @(negedge clk);
            start = 1'b0;
            check({tag, "_no_rerun_busy"}, busy, 0);
            repeat (3) @(negedge clk);
            check({tag, "_no_rerun_out0"}, out_flat[15:0], e0);
            check({tag, "_no_rerun_valid"}, out_valid, 1);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            act_rom[i] = '0;
            w_rom[i]   = '0;
        end
        for (int i = 0; i < 4; i++) begin
            act_rom[i]      = 16'h0100;
            act_rom[16 + i] = 16'h7FFF;
            w_rom[i]        = 16'h0100;
            w_rom[5 + i]    = 16'hFF00;
            w_rom[32 + i]   = 16'h7FFF;
            w_rom[37 + i]   = 16'h8001;
            w_rom[53 + i]   = 16'h0040;
        end
        w_rom[4] = 16'h0080;

        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", out_valid, 0);
        check("rst_addr_in", addr_in, 0);
        check("rst_addr_w", addr_w, 0);
        check("rst_out_flat", out_flat, 0);
        rst = 1'b0;
        check_en = 1'b1;

        run_layer("t1_ident", 2'd0, 0, 0, 16'h0480, 16'hFC00, 1'b0);
        run_layer("t2_relu",  2'd1, 0, 0, 16'h0480, 16'h0000, 1'b0);
        run_layer("t3_sat",   2'd0, 16, 32, 16'h7FFF, 16'h8000, 1'b0);
        run_layer("t4_hsig_a", 2'd2, 0, 48, 16'h0080, 16'h00C0, 1'b0);
        run_layer("t4_hsig_b", 2'd2, 0, 0, 16'h0100, 16'h0000, 1'b0);
        run_layer("t4_mode3", 2'd3, 0, 0, 16'h0480, 16'hFC00, 1'b0);

        @(negedge clk);
        act_mode = 2'd1; in_base = '0; w_base = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5_busy", busy, 0);
        check("t5_addr_in", addr_in, 0);
        check("t5_addr_w", addr_w, 0);
        check("t5_out_flat", out_flat, 0);
        check("t5_valid", out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        run_layer("t5_restart", 2'd0, 0, 0, 16'h0480, 16'hFC00, 1'b0);

        run_layer("t6_ignore", 2'd1, 0, 0, 16'h0480, 16'h0000, 1'b1);

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
